// File: rtl/universal_shift_burst_if.sv
// Control, data and status bundle for universal_shift_burst.
// The master side drives operations; the slave side is the shift register itself.
interface universal_shift_burst_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
);
  logic             Sclr;
  logic             Sset;
  logic             enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] Data;
  logic [STEP-1:0]  shift_in;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic [STEP-1:0]  shift_out;
  logic             busy;
  logic             done;

  modport master (
    output Sclr, Sset, enable, mode, Data, shift_in, start, count,
    input  q, shift_out, busy, done
  );

  modport slave (
    input  Sclr, Sset, enable, mode, Data, shift_in, start, count,
    output q, shift_out, busy, done
  );
endinterface

// File: rtl/universal_shift_burst.sv
// Universal shift register with shift/rotate/arithmetic modes, STEP bits per operation,
// and a burst engine that repeats one latched mode for a programmed number of shifts.
module universal_shift_burst #(
  parameter int               WIDTH      = 8,
  parameter int               STEP       = 1,
  parameter int               CNT_W      = 8,
  parameter logic [WIDTH-1:0] SSET_VALUE = {WIDTH{1'b1}}
) (
  input logic                    clock,
  input logic                    Aclr,
  universal_shift_burst_if.slave io
);

  // state   | meaning
  // IDLE    | single-step operation; start may launch a burst
  // BURST   | shifting with latched bmode once per enabled cycle until rem reaches 0
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [STEP-1:0]  r_shift_out;
  logic [2:0]       r_bmode;
  logic [CNT_W-1:0] r_rem;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [STEP-1:0]  w_so_nxt;
  logic [2:0]       w_bmode_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_done_nxt;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_shift_q;
  logic [STEP-1:0]  w_shift_so;
  logic             w_mode_is_shift;

  assign w_mode_is_shift = (io.mode >= MODE_SHL) && (io.mode <= MODE_ASR);

  // One shared shifter: the latched mode drives it during a burst, the live mode otherwise.
  always_comb begin
    w_op       = (r_state == ST_BURST) ? r_bmode : io.mode;
    w_shift_q  = r_q;
    w_shift_so = r_shift_out;
    case (w_op)
      MODE_SHL: begin
        w_shift_q  = {r_q[WIDTH-1-STEP:0], io.shift_in};
        w_shift_so = r_q[WIDTH-1 -: STEP];
      end
      MODE_SHR: begin
        w_shift_q  = {io.shift_in, r_q[WIDTH-1:STEP]};
        w_shift_so = r_q[STEP-1:0];
      end
      MODE_ROL: begin
        w_shift_q  = {r_q[WIDTH-1-STEP:0], r_q[WIDTH-1 -: STEP]};
        w_shift_so = r_q[WIDTH-1 -: STEP];
      end
      MODE_ROR: begin
        w_shift_q  = {r_q[STEP-1:0], r_q[WIDTH-1:STEP]};
        w_shift_so = r_q[STEP-1:0];
      end
      MODE_ASR: begin
        w_shift_q  = {{STEP{r_q[WIDTH-1]}}, r_q[WIDTH-1:STEP]};
        w_shift_so = r_q[STEP-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_so_nxt    = r_shift_out;
    w_bmode_nxt = r_bmode;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    if (io.enable) begin
      if (io.Sclr) begin
        w_q_nxt     = '0;
        w_state_nxt = ST_IDLE;
      end else if (io.Sset) begin
        w_q_nxt     = SSET_VALUE;
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (io.start) begin
              // A degenerate burst request completes immediately without touching q.
              if (w_mode_is_shift && (io.count != '0)) begin
                w_state_nxt = ST_BURST;
                w_bmode_nxt = io.mode;
                w_rem_nxt   = io.count;
              end else begin
                w_done_nxt = 1'b1;
              end
            end else if (io.mode == MODE_LOAD) begin
              w_q_nxt = io.Data;
            end else if (w_mode_is_shift) begin
              w_q_nxt  = w_shift_q;
              w_so_nxt = w_shift_so;
            end
          end
          ST_BURST: begin
            w_q_nxt   = w_shift_q;
            w_so_nxt  = w_shift_so;
            w_rem_nxt = r_rem - REM_ONE;
            if (r_rem == REM_ONE) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge Aclr) begin
    if (Aclr) begin
      r_state     <= ST_IDLE;
      r_q         <= '0;
      r_shift_out <= '0;
      r_bmode     <= '0;
      r_rem       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_q         <= w_q_nxt;
      r_shift_out <= w_so_nxt;
      r_bmode     <= w_bmode_nxt;
      r_rem       <= w_rem_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign io.q         = r_q;
  assign io.shift_out = r_shift_out;
  assign io.busy      = (r_state == ST_BURST);
  assign io.done      = r_done;

endmodule

// File: tb/tb_universal_shift_burst.sv
// Bench for universal_shift_burst: scripted scenarios plus randomized traffic checked
// against an arithmetic reference model (WIDTH=8, STEP=1 main instance; STEP=2 second instance).
module tb_universal_shift_burst;
  localparam int W  = 8;
  localparam int S  = 1;
  localparam int M  = (1 << W) - 1;
  localparam int SM = (1 << S) - 1;

  logic clock = 1'b0;
  logic Aclr;
  int   n_vec = 0;
  int   n_err = 0;

  universal_shift_burst_if #(.WIDTH(8), .STEP(1), .CNT_W(8)) bus  ();
  universal_shift_burst_if #(.WIDTH(8), .STEP(2), .CNT_W(8)) bus2 ();

  universal_shift_burst #(.WIDTH(8), .STEP(1), .CNT_W(8), .SSET_VALUE(8'hFF)) dut (
    .clock(clock), .Aclr(Aclr), .io(bus));
  universal_shift_burst #(.WIDTH(8), .STEP(2), .CNT_W(8), .SSET_VALUE(8'hFF)) dut2 (
    .clock(clock), .Aclr(Aclr), .io(bus2));

  always #5 clock = ~clock;

  // reference model state
  int m_q, m_so, m_rem, m_bmode;
  bit m_busy, m_done;

  task automatic model_reset();
    m_q = 0; m_so = 0; m_rem = 0; m_bmode = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_apply(input int op, input int sin);
    int old;
    old = m_q;
    case (op)
      2: begin m_so = old >> (W - S); m_q = ((old << S) | sin) & M; end
      3: begin m_so = old & SM; m_q = (old >> S) | (sin << (W - S)); end
      4: begin m_so = old >> (W - S); m_q = ((old << S) | m_so) & M; end
      5: begin m_so = old & SM; m_q = (old >> S) | (m_so << (W - S)); end
      6: begin
        m_so = old & SM;
        m_q  = (old >> S) | (((old >> (W - 1)) != 0) ? (SM << (W - S)) : 0);
      end
      default: ;
    endcase
  endtask

  task automatic model_step();
    int md;
    md = int'(bus.mode);
    if (!bus.enable) begin m_done = 0; return; end
    m_done = 0;
    if (bus.Sclr) begin m_q = 0; m_busy = 0; return; end
    if (bus.Sset) begin m_q = 8'hFF; m_busy = 0; return; end
    if (!m_busy) begin
      if (bus.start) begin
        if (md >= 2 && md <= 6 && bus.count != 0) begin
          m_busy = 1; m_bmode = md; m_rem = int'(bus.count);
        end else m_done = 1;
      end else if (md == 1) m_q = int'(bus.Data);
      else if (md >= 2 && md <= 6) model_apply(md, int'(bus.shift_in));
    end else begin
      model_apply(m_bmode, int'(bus.shift_in));
      m_rem = m_rem - 1;
      if (m_rem == 0) begin m_busy = 0; m_done = 1; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Sclr = 0; bus.Sset = 0; bus.enable = 1; bus.mode = 3'b000; bus.Data = '0;
    bus.shift_in = '0; bus.start = 0; bus.count = '0;
    bus2.Sclr = 0; bus2.Sset = 0; bus2.enable = 1; bus2.mode = 3'b000; bus2.Data = '0;
    bus2.shift_in = '0; bus2.start = 0; bus2.count = '0;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.mode = 3'b001; bus.Data = v; tick(); bus.mode = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    Aclr = 1;
    #2;
    n_vec += 4;
    if (bus.q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h expected 00", bus.q); end
    if (bus.shift_out !== 1'b0) begin n_err++; $display("FAIL reset_so: got %b expected 0", bus.shift_out); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    @(posedge clock); #1;
    Aclr = 0;
    model_reset();
    n_vec++;
    if (bus2.q !== 8'h00) begin n_err++; $display("FAIL reset_q2: got %h expected 00", bus2.q); end
  endtask

  task automatic test_load_shl_hold();
    do_load(8'hA5);
    bus.mode = 3'b010; bus.shift_in = 1'b1; tick();
    n_vec += 2;
    if (bus.q !== 8'h4B) begin n_err++; $display("FAIL shl_q: got %h expected 4b", bus.q); end
    if (bus.shift_out !== 1'b1) begin n_err++; $display("FAIL shl_so: got %b expected 1", bus.shift_out); end
    bus.mode = 3'b000; bus.shift_in = 1'b0; tick();
    n_vec++;
    if (bus.q !== 8'h4B) begin n_err++; $display("FAIL hold_q: got %h expected 4b", bus.q); end
  endtask

  task automatic test_asr();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hC0; exp_q[1] = 8'hE0; exp_q[2] = 8'hF0;
    do_load(8'h80);
    bus.mode = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec += 2;
      if (bus.q !== exp_q[i]) begin n_err++; $display("FAIL asr_q%0d: got %h expected %h", i, bus.q, exp_q[i]); end
      if (bus.shift_out !== 1'b0) begin n_err++; $display("FAIL asr_so%0d: got %b expected 0", i, bus.shift_out); end
    end
    bus.mode = 3'b000;
  endtask

  task automatic test_burst_ror();
    int busy_cnt, k;
    bit seen;
    do_load(8'h81);
    bus.mode = 3'b101; bus.count = 8'd4; bus.start = 1; tick();
    bus.start = 0; bus.mode = 3'b000;
    busy_cnt = bus.busy ? 1 : 0;
    seen = 0; k = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.done) begin seen = 1; k = i; end
    end
    n_vec += 5;
    if (!seen) begin n_err++; $display("FAIL ror_done_timeout: got no done expected done"); end
    if (k != 4) begin n_err++; $display("FAIL ror_latency: got %0d expected 4", k); end
    if (busy_cnt != 4) begin n_err++; $display("FAIL ror_busy_cycles: got %0d expected 4", busy_cnt); end
    if (bus.q !== 8'h18) begin n_err++; $display("FAIL ror_q: got %h expected 18", bus.q); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ror_busy_at_done: got %b expected 0", bus.busy); end
    tick();
    n_vec++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL ror_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_burst_pause();
    int total;
    bit seen;
    do_load(8'h81);
    bus.mode = 3'b101; bus.count = 8'd4; bus.start = 1; tick();
    bus.start = 0; bus.mode = 3'b000;
    tick(); tick();
    bus.enable = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec += 3;
      if (bus.q !== 8'h60) begin n_err++; $display("FAIL pause_q%0d: got %h expected 60", i, bus.q); end
      if (bus.busy !== 1'b1) begin n_err++; $display("FAIL pause_busy%0d: got %b expected 1", i, bus.busy); end
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL pause_done%0d: got %b expected 0", i, bus.done); end
    end
    bus.enable = 1;
    total = 5; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      total++;
      if (bus.done) seen = 1;
    end
    n_vec += 2;
    if (!seen || total != 7) begin n_err++; $display("FAIL pause_latency: got %0d expected 7", total); end
    if (bus.q !== 8'h18) begin n_err++; $display("FAIL pause_q_final: got %h expected 18", bus.q); end
  endtask

  task automatic test_abort();
    do_load(8'hF0);
    bus.mode = 3'b101; bus.count = 8'd10; bus.start = 1; tick();
    bus.start = 0; bus.mode = 3'b000;
    tick(); tick(); tick();
    bus.Sclr = 1; tick(); bus.Sclr = 0;
    n_vec += 3;
    if (bus.q !== 8'h00) begin n_err++; $display("FAIL sclr_q: got %h expected 00", bus.q); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sclr_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL sclr_done: got %b expected 0", bus.done); end
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL sclr_after: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    bus.mode = 3'b010; bus.count = 8'd6; bus.start = 1; tick();
    bus.start = 0; bus.mode = 3'b000;
    tick();
    bus.Sset = 1; tick(); bus.Sset = 0;
    n_vec += 2;
    if (bus.q !== 8'hFF) begin n_err++; $display("FAIL sset_q: got %h expected ff", bus.q); end
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL sset_abort: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    do_load(8'h55);
    bus.mode = 3'b010; bus.shift_in = 1; bus.count = 8'd8; bus.start = 1; tick();
    bus.start = 0; bus.mode = 3'b000;
    tick(); tick(); tick();
    #2 Aclr = 1;
    #1;
    n_vec += 4;
    if (bus.q !== 8'h00) begin n_err++; $display("FAIL aclr_q: got %h expected 00", bus.q); end
    if (bus.shift_out !== 1'b0) begin n_err++; $display("FAIL aclr_so: got %b expected 0", bus.shift_out); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL aclr_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL aclr_done: got %b expected 0", bus.done); end
    #1 Aclr = 0;
    model_reset();
    bus.shift_in = 0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.q !== 8'h00) begin
      n_err++; $display("FAIL aclr_after: got busy=%b q=%h expected 0 00", bus.busy, bus.q);
    end
  endtask

  task automatic test_step2();
    bus2.mode = 3'b001; bus2.Data = 8'hC3; tick();
    bus2.mode = 3'b011; bus2.shift_in = 2'b10; tick();
    n_vec += 2;
    if (bus2.q !== 8'hB0) begin n_err++; $display("FAIL step2_q: got %h expected b0", bus2.q); end
    if (bus2.shift_out !== 2'b11) begin n_err++; $display("FAIL step2_so: got %b expected 11", bus2.shift_out); end
    bus2.count = 8'd0; bus2.start = 1; tick();
    bus2.start = 0; bus2.mode = 3'b000;
    n_vec += 3;
    if (bus2.done !== 1'b1) begin n_err++; $display("FAIL step2_zero_done: got %b expected 1", bus2.done); end
    if (bus2.q !== 8'hB0) begin n_err++; $display("FAIL step2_zero_q: got %h expected b0", bus2.q); end
    if (bus2.busy !== 1'b0) begin n_err++; $display("FAIL step2_zero_busy: got %b expected 0", bus2.busy); end
    tick();
    n_vec++;
    if (bus2.done !== 1'b0) begin n_err++; $display("FAIL step2_done_pulse: got %b expected 0", bus2.done); end
  endtask

  task automatic test_count_max();
    int k;
    do_load(8'($urandom));
    bus.mode = 3'b010; bus.count = 8'd255; bus.start = 1; tick();
    bus.start = 0;
    k = 0;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      bus.shift_in = 1'($urandom);
      bus.mode = 3'($urandom);
      tick();
      n_vec += 2;
      if (bus.q !== m_q[7:0]) begin n_err++; $display("FAIL max_q@%0d: got %h expected %h", i, bus.q, m_q[7:0]); end
      if (bus.busy !== m_busy) begin n_err++; $display("FAIL max_busy@%0d: got %b expected %b", i, bus.busy, m_busy); end
      if (bus.done) k = i;
    end
    n_vec++;
    if (k != 255) begin n_err++; $display("FAIL max_latency: got %0d expected 255", k); end
    bus.mode = 3'b000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.enable   = ($urandom % 8) != 0;
      bus.Sclr     = ($urandom % 40) == 0;
      bus.Sset     = ($urandom % 40) == 0;
      bus.mode     = 3'($urandom);
      bus.start    = ($urandom % 4) == 0;
      bus.count    = (($urandom % 8) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
      bus.Data     = 8'($urandom);
      bus.shift_in = 1'($urandom);
      tick();
      n_vec += 4;
      if (bus.q !== m_q[7:0]) begin n_err++; $display("FAIL rnd_q@%0d: got %h expected %h", i, bus.q, m_q[7:0]); end
      if (bus.shift_out !== m_so[0]) begin n_err++; $display("FAIL rnd_so@%0d: got %b expected %b", i, bus.shift_out, m_so[0]); end
      if (bus.busy !== m_busy) begin n_err++; $display("FAIL rnd_busy@%0d: got %b expected %b", i, bus.busy, m_busy); end
      if (bus.done !== m_done) begin n_err++; $display("FAIL rnd_done@%0d: got %b expected %b", i, bus.done, m_done); end
    end
    idle_inputs();
  endtask

  initial begin
    Aclr = 1'b0;
    test_reset();
    test_load_shl_hold();
    test_asr();
    test_burst_ror();
    test_burst_pause();
    test_abort();
    test_step2();
    test_count_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
